// File: rtl/nanov_pkg.sv
// Shared sizing constants for the nanoV bit-serial register file.
package nanov_pkg;
    localparam int XLEN          = 32;
    localparam int REG_ADDR_BITS = 4;
    localparam int NUM_REGS      = 16;
    localparam logic [REG_ADDR_BITS-1:0] REG_ZERO = '0;
endpackage

// File: rtl/nanov_serial_reg.sv
// One XLEN-bit circulating shift register; the caller supplies the bit that
// enters at the top (either new write data or the bit leaving at position 0).
module nanov_serial_reg
    import nanov_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input  logic clk,
    input  logic rstn,
    input  logic shift_in,
    output logic bit0,
    output logic bit1
);

    logic [WIDTH-1:0] r;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r <= '0;
        end else begin
            r <= {shift_in, r[WIDTH-1:1]};
        end
    end

    assign bit0 = r[0];
    assign bit1 = r[1];

endmodule

// File: rtl/nanov_registers_serial.sv
// Bit-serial RV32E register file: x1..x15 rotate one bit per clock, LSB first;
// x0 has no storage and always reads as zero.
module nanov_registers_serial
    import nanov_pkg::*;
#(
    parameter int REG_ADDR_BITS = nanov_pkg::REG_ADDR_BITS,
    parameter int NUM_REGS      = nanov_pkg::NUM_REGS,
    parameter int XLEN          = nanov_pkg::XLEN
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     wr_en,
    input  logic                     wr_en_next,
    input  logic                     read_through,
    input  logic [REG_ADDR_BITS-1:0] rs1,
    input  logic [REG_ADDR_BITS-1:0] rs2,
    input  logic [REG_ADDR_BITS-1:0] rd,
    output logic                     data_rs1,
    output logic                     data_rs2,
    input  logic                     data_rd,
    input  logic                     data_rd_next
);

    localparam logic [REG_ADDR_BITS-1:0] ZERO_SEL = REG_ADDR_BITS'(REG_ZERO);

    logic [NUM_REGS-1:1] reg_lsb;
    logic [NUM_REGS-1:1] reg_nxt;
    logic [NUM_REGS-1:1] reg_in;

    for (genvar i = 1; i < NUM_REGS; i++) begin : g_reg
        // A selected write replaces the recirculated bit for this phase only.
        assign reg_in[i] = (wr_en && rd == REG_ADDR_BITS'(i)) ? data_rd : reg_lsb[i];

        nanov_serial_reg #(
            .WIDTH (XLEN)
        ) u_reg (
            .clk      (clk),
            .rstn     (rstn),
            .shift_in (reg_in[i]),
            .bit0     (reg_lsb[i]),
            .bit1     (reg_nxt[i])
        );
    end

    // Bit 1 now is bit 0 after this edge's shift, so the output flop lines
    // up with the phase that follows.
    logic rs1_stored;
    logic rs2_stored;

    always_comb begin
        rs1_stored = 1'b0;
        rs2_stored = 1'b0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (rs1 == REG_ADDR_BITS'(i)) rs1_stored = reg_nxt[i];
            if (rs2 == REG_ADDR_BITS'(i)) rs2_stored = reg_nxt[i];
        end
    end

    logic fwd_en;
    assign fwd_en = read_through && wr_en_next;

    function automatic logic read_bit(
        input logic [REG_ADDR_BITS-1:0] rs,
        input logic                     stored
    );
        if (rs == ZERO_SEL) return 1'b0;
        if (fwd_en && rs == rd) return data_rd_next;
        return stored;
    endfunction

    always_ff @(posedge clk) begin
        if (!rstn) begin
            data_rs1 <= 1'b0;
            data_rs2 <= 1'b0;
        end else begin
            data_rs1 <= read_bit(rs1, rs1_stored);
            data_rs2 <= read_bit(rs2, rs2_stored);
        end
    end

endmodule

// File: tb/tb_nanov_registers_serial.sv
// Schedule-driven bench: per-cycle stimulus tables, expected words queued as
// reads are scheduled and compared against reassembled serial output.
module tb_nanov_registers_serial;

    localparam int MAXC = 8 * 32;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       wr_en = 1'b0;
    logic       wr_en_next = 1'b0;
    logic       read_through = 1'b0;
    logic [3:0] rs1 = '0;
    logic [3:0] rs2 = '0;
    logic [3:0] rd = '0;
    logic       data_rd = 1'b0;
    logic       data_rd_next = 1'b0;
    logic       data_rs1;
    logic       data_rs2;

    always #5 clk = ~clk;

    nanov_registers_serial dut (
        .clk          (clk),
        .rstn         (rstn),
        .wr_en        (wr_en),
        .wr_en_next   (wr_en_next),
        .read_through (read_through),
        .rs1          (rs1),
        .rs2          (rs2),
        .rd           (rd),
        .data_rs1     (data_rs1),
        .data_rs2     (data_rs2),
        .data_rd      (data_rd),
        .data_rd_next (data_rd_next)
    );

    logic       s_rstn [MAXC];
    logic       s_we   [MAXC];
    logic       s_wen  [MAXC];
    logic       s_rt   [MAXC];
    logic       s_d    [MAXC];
    logic       s_dn   [MAXC];
    logic [3:0] s_rs1  [MAXC];
    logic [3:0] s_rs2  [MAXC];
    logic [3:0] s_rd   [MAXC];
    logic       o1     [MAXC];
    logic       o2     [MAXC];

    typedef struct packed {
        logic [31:0] exp;
        logic [15:0] start;
        logic [1:0]  port;
        logic [7:0]  tag;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic clear_sched();
        for (int c = 0; c < MAXC; c++) begin
            s_rstn[c] = 1'b1; s_we[c] = 1'b0; s_wen[c] = 1'b0; s_rt[c] = 1'b0;
            s_d[c] = 1'b0; s_dn[c] = 1'b0; s_rs1[c] = '0; s_rs2[c] = '0; s_rd[c] = '0;
            o1[c] = 1'bx; o2[c] = 1'bx;
        end
        sb.delete();
    endtask

    task automatic sched_write(input int w, input logic [3:0] r, input logic [31:0] v);
        for (int k = 0; k < 32; k++) begin
            int c;
            c = w * 32 + k;
            s_we[c] = 1'b1;
            s_rd[c] = r;
            s_d[c]  = v[k];
            if (c > 0) begin
                s_wen[c-1] = 1'b1;
                s_dn[c-1]  = v[k];
            end
        end
    endtask

    // Selects are applied one cycle ahead of the phase they read.
    task automatic sched_read(input int w, input int port, input logic [3:0] r,
                              input logic rt, input logic [31:0] exp, input int tag);
        exp_t e;
        for (int k = 0; k < 32; k++) begin
            int c;
            c = w * 32 + k;
            if (c > 0) begin
                if (port == 1) s_rs1[c-1] = r;
                else           s_rs2[c-1] = r;
                s_rt[c-1] = rt;
            end
        end
        e.exp = exp; e.start = 16'(w * 32); e.port = 2'(port); e.tag = 8'(tag);
        sb.push_back(e);
    endtask

    task automatic run_sched(input int ncyc);
        rstn = 1'b0; wr_en = 1'b0; wr_en_next = 1'b0; read_through = 1'b0;
        rs1 = '0; rs2 = '0; rd = '0; data_rd = 1'b0; data_rd_next = 1'b0;
        @(posedge clk);
        #1;
        for (int c = 0; c < ncyc; c++) begin
            o1[c] = data_rs1;
            o2[c] = data_rs2;
            rstn = s_rstn[c]; wr_en = s_we[c]; wr_en_next = s_wen[c];
            read_through = s_rt[c]; data_rd = s_d[c]; data_rd_next = s_dn[c];
            rs1 = s_rs1[c]; rs2 = s_rs2[c]; rd = s_rd[c];
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [31:0] assemble(input int start, input int port);
        logic [31:0] v;
        for (int k = 0; k < 32; k++) v[k] = (port == 1) ? o1[start+k] : o2[start+k];
        return v;
    endfunction

    task automatic test_reset();
        exp_t e;
        logic [31:0] got;
        rstn = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (data_rs1 !== 1'b0) begin
            n_fail++; $display("FAIL reset_rs1: got %b expected 0", data_rs1);
        end
        n_checks++;
        if (data_rs2 !== 1'b0) begin
            n_fail++; $display("FAIL reset_rs2: got %b expected 0", data_rs2);
        end
        clear_sched();
        sched_read(0, 1, 4'd5, 1'b0, 32'h0000_0000, 1);
        sched_read(0, 2, 4'd0, 1'b0, 32'h0000_0000, 2);
        run_sched(32);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            got = assemble(int'(e.start), int'(e.port));
            n_checks++;
            if (got !== e.exp) begin
                n_fail++;
                $display("FAIL reset_read tag%0d rs%0d: got %h expected %h", e.tag, e.port, got, e.exp);
            end
        end
    endtask

    task automatic test_write_read();
        exp_t e;
        logic [31:0] got;
        clear_sched();
        sched_write(0, 4'd3, 32'hDEAD_BEEF);
        sched_read(0, 1, 4'd3, 1'b0, 32'h0000_0000, 1);
        sched_read(1, 1, 4'd3, 1'b0, 32'hDEAD_BEEF, 2);
        sched_read(1, 2, 4'd3, 1'b0, 32'hDEAD_BEEF, 3);
        run_sched(64);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            got = assemble(int'(e.start), int'(e.port));
            n_checks++;
            if (got !== e.exp) begin
                n_fail++;
                $display("FAIL write_read tag%0d rs%0d: got %h expected %h", e.tag, e.port, got, e.exp);
            end
        end
    endtask

    task automatic test_read_through();
        exp_t e;
        logic [31:0] got;
        for (int pass = 0; pass < 2; pass++) begin
            clear_sched();
            sched_write(0, 4'd7, 32'h1234_5678);
            sched_write(1, 4'd7, 32'hCAFE_F00D);
            if (pass == 0) begin
                sched_read(1, 1, 4'd7, 1'b1, 32'hCAFE_F00D, 1);
                sched_read(1, 2, 4'd7, 1'b1, 32'hCAFE_F00D, 2);
            end else begin
                sched_read(1, 1, 4'd7, 1'b0, 32'h1234_5678, 3);
                sched_read(2, 1, 4'd7, 1'b0, 32'hCAFE_F00D, 4);
            end
            run_sched(96);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                got = assemble(int'(e.start), int'(e.port));
                n_checks++;
                if (got !== e.exp) begin
                    n_fail++;
                    $display("FAIL read_through tag%0d rs%0d: got %h expected %h", e.tag, e.port, got, e.exp);
                end
            end
        end
    endtask

    task automatic test_x0();
        exp_t e;
        logic [31:0] got;
        clear_sched();
        sched_write(0, 4'd2, 32'h0F0F_0F0F);
        sched_write(1, 4'd0, 32'hFFFF_FFFF);
        sched_read(1, 1, 4'd0, 1'b1, 32'h0000_0000, 1);
        sched_read(2, 1, 4'd2, 1'b0, 32'h0F0F_0F0F, 2);
        sched_read(2, 2, 4'd0, 1'b0, 32'h0000_0000, 3);
        run_sched(96);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            got = assemble(int'(e.start), int'(e.port));
            n_checks++;
            if (got !== e.exp) begin
                n_fail++;
                $display("FAIL x0 tag%0d rs%0d: got %h expected %h", e.tag, e.port, got, e.exp);
            end
        end
    endtask

    task automatic test_circulation();
        exp_t e;
        logic [31:0] got;
        clear_sched();
        sched_write(0, 4'd1, 32'hA5A5_A5A5);
        sched_write(1, 4'd15, 32'h5A5A_5A5A);
        sched_read(2, 1, 4'd1, 1'b0, 32'hA5A5_A5A5, 1);
        sched_read(2, 2, 4'd15, 1'b0, 32'h5A5A_5A5A, 2);
        sched_read(5, 1, 4'd1, 1'b0, 32'hA5A5_A5A5, 3);
        sched_read(5, 2, 4'd15, 1'b0, 32'h5A5A_5A5A, 4);
        run_sched(192);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            got = assemble(int'(e.start), int'(e.port));
            n_checks++;
            if (got !== e.exp) begin
                n_fail++;
                $display("FAIL circulation tag%0d rs%0d: got %h expected %h", e.tag, e.port, got, e.exp);
            end
        end
    endtask

    task automatic test_reset_mid_word();
        exp_t e;
        logic [31:0] got;
        logic [9:0]  head;
        clear_sched();
        sched_write(0, 4'd4, 32'hFFFF_FFFF);
        // Read x4 in the next word, then reset at bit 10 (cycle 42).
        for (int c = 31; c < 75; c++) s_rs1[c] = 4'd4;
        s_rstn[42] = 1'b0;
        e.exp = 32'h0000_0000; e.start = 16'd43; e.port = 2'd1; e.tag = 8'd1;
        sb.push_back(e);
        run_sched(75);
        for (int k = 0; k < 10; k++) head[k] = o1[32+k];
        n_checks++;
        if (head !== 10'h3FF) begin
            n_fail++;
            $display("FAIL mid_reset_before: got %h expected %h", head, 10'h3FF);
        end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            got = assemble(int'(e.start), int'(e.port));
            n_checks++;
            if (got !== e.exp) begin
                n_fail++;
                $display("FAIL mid_reset_after tag%0d rs%0d: got %h expected %h", e.tag, e.port, got, e.exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_read_through();
        test_x0();
        test_circulation();
        test_reset_mid_word();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
